bus_grant_fsm: RTL
==================

Name: bus_grant_fsm

Overview:
- Sequential grant stage directly downstream of the 4-to-2 priority encoder in the bus arbiter.
- Samples the encoder's {V,Y} output and turns it into a registered one-hot bus grant.
- Holds the grant until the owner releases the bus or a hold timeout expires, then inserts a one-cycle dead cycle before re-arbitrating.
- Requester 0 has the highest priority and requester 3 the lowest; this priority comes from the encoder, not from this block.

Parameters:
- MAX_HOLD, 16: maximum number of cycles a single grant may stay asserted. Legal range 2..2^CNT_W.
- CNT_W, 4: width of the hold counter. It must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  raw request lines, the same vector that drives the encoder's Data input; bit 0 is highest priority.
- enc_y  input  2  encoder Y, the index of the highest-priority active request.
- enc_v  input  1  encoder V; 1 when any request is active.
- bus_done  input  1  the current owner signals end of transfer; single-cycle pulse.
- grant  output  4  registered one-hot grant; 0 when no owner.
- owner  output  2  registered index of the current owner; valid only while busy=1.
- busy  output  1  registered; 1 while in GRANT.
- timeout  output  1  registered single-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, named clk and reset.
- Reset values: state=IDLE, grant=4'b0000, owner=2'b00, busy=0, timeout=0, hold_cnt=0.
- Reset asserted mid-grant clears grant and busy immediately, without waiting for a clock edge.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If enc_v=1 at a rising edge: owner<=enc_y, grant<=one-hot(enc_y), busy<=1, hold_cnt<=0, go to GRANT.
  - Otherwise remain in IDLE with all outputs 0.
- GRANT (hold_cnt increments each cycle). At each edge, in priority order:
  - (a) bus_done=1 or req[owner]=0: grant<=0, busy<=0, go to RELEASE, no timeout.
  - (b) otherwise, if hold_cnt==MAX_HOLD-1: grant<=0, busy<=0, timeout<=1 for one cycle, go to RELEASE.
  - (c) otherwise stay in GRANT.
  - The grant is therefore asserted for at most MAX_HOLD cycles.
- RELEASE: one dead cycle with grant=0 to avoid bus contention; unconditionally go to IDLE. timeout returns to 0.
- Latency:
  - Request visible at edge k produces grant high after edge k.
  - Back-to-back handover gives exactly 2 cycles with grant=0 (RELEASE plus IDLE sample).
- A higher-priority request arriving during GRANT does not preempt; it is served at the next IDLE sample.
- enc_y is ignored while enc_v=0. The block does not check enc_y against req.
- Simultaneous events: bus_done or a req drop in the same cycle as the hold limit counts as a normal release, with no timeout pulse.
- hold_cnt never wraps; it is cleared on entry to GRANT.

Decomposition:
- Shared package bus_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
  - N_REQ=4.
  - IDX_W=2.
- Sub-module hold_counter (CNT_W-wide counter with clear, enable and a terminal-count flag at MAX_HOLD-1) is natural.
- The one-hot decode stays inline.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles: grant=0, busy=0, timeout=0 throughout.
- req=4'b1010: encoder gives V=1, Y=01, so after one edge grant=4'b0010, owner=1, busy=1. Drop req[1] 3 cycles later: one cycle in RELEASE then 4'b1000 granted; grant=0 for exactly 2 cycles.
- req=4'b0001 held, bus_done never asserted, MAX_HOLD=16: grant=4'b0001 for exactly 16 cycles, then timeout=1 for one cycle and grant=0 for 2 cycles, then 4'b0001 is re-granted.
- bus_done pulse on the same cycle hold_cnt==15: release occurs with timeout=0.
- Owner 3 granted (req=4'b1000), then req[0] asserted mid-grant: grant stays 4'b1000 until bus_done, then 4'b0001 is granted (no preemption).
- Assert reset asynchronously between edges during GRANT: grant=0 and busy=0 immediately. After reset is released with req=4'b0100: grant=4'b0100 on the first edge.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared constants for the bus arbiter grant stage.
package bus_arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
endpackage

// File: rtl/hold_counter.sv
// hold_counter: grant-age counter with clear, enable and a terminal-count flag at MAX_HOLD-1.
module hold_counter #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q;
    assign tc_o = cnt_q == CNT_W'(MAX_HOLD - 1);
    // Saturates at terminal count so it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && !tc_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/bus_grant_fsm.sv
// bus_grant_fsm: turns the priority encoder's {V,Y} into a registered one-hot grant
// held until release or hold timeout, followed by one dead cycle.
module bus_grant_fsm
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] enc_y,
    input  logic             enc_v,
    input  logic             bus_done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             timeout
);
    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             busy_q, busy_d, timeout_q, timeout_d;
    logic             rel, tc, clr, en;

    hold_counter #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .en_i  (en),
        .tc_o  (tc)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        rel       = bus_done || !req[owner_q];
        case (state_q)
            ST_IDLE: if (enc_v) begin
                state_d = ST_GRANT;
                grant_d = N_REQ'(1) << enc_y;
                owner_d = enc_y;
                busy_d  = 1'b1;
                clr     = 1'b1;
            end
            // A normal release outranks the hold limit, so no timeout pulse then.
            ST_GRANT: begin
                en = 1'b1;
                if (rel || tc) begin
                    state_d   = ST_RELEASE;
                    grant_d   = '0;
                    owner_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = !rel;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule
